data_mem_ctrl: RTL and testbench
================================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter DATA_W, default 16: data word width; SHALL be a multiple of 8 and at least 8.
REQ-002 Parameter ADDR_W, default 6: request address width.
REQ-003 Parameter DEPTH, default 64: number of words; SHALL satisfy 1 <= DEPTH <= 2^ADDR_W.
REQ-004 Parameter RD_LAT, default 1: response latency in cycles; legal range 1..4.
REQ-005 Parameter INIT_ON_RESET, default 1: 1 = zero-fill sweep after reset; 0 = ready immediately.
REQ-006 clk  input  1  single clock; all state changes on its rising edge.
REQ-007 clear_n  input  1  asynchronous, active-low reset.
REQ-008 req_valid  input  1  request present.
REQ-009 req_ready  output  1  block accepts a request this cycle.
REQ-010 req_write  input  1  1 = write, 0 = read.
REQ-011 req_addr  input  ADDR_W  word address.
REQ-012 req_wdata  input  DATA_W  write data.
REQ-013 req_wmask  input  DATA_W/8  byte enables for a write.
REQ-014 init_start  input  1  single-cycle pulse requesting a zero-fill sweep.
REQ-015 rsp_valid  output  1  response valid; held for one cycle only.
REQ-016 rsp_rdata  output  DATA_W  read data; 0 for write responses, error responses, and whenever rsp_valid=0.
REQ-017 rsp_err  output  1  address out of range (req_addr >= DEPTH); qualified by rsp_valid.

Function
REQ-018 The FSM SHALL have exactly two states, INIT and RUN; req_ready=1 only in RUN.
REQ-019 In INIT, an internal counter SHALL write 0 to address 0, 1, ..., DEPTH-1, one word per cycle.
REQ-020 After the DEPTH-1 write, the FSM SHALL enter RUN on the next edge; the sweep takes exactly DEPTH cycles.
REQ-021 A request is accepted on a rising edge where req_valid=1 and req_ready=1; there is no other acceptance condition.
REQ-022 Every accepted request SHALL produce exactly one response, rsp_valid=1 exactly RD_LAT cycles after acceptance; responses stay in order.
REQ-023 The response pipeline SHALL accept a new request every cycle with no bubbles; there is no response back-pressure.
REQ-024 An in-range write SHALL update only the bytes whose req_wmask bit is 1 (bit i covers data bits 8i+7:8i); mask all-zero writes nothing.
REQ-025 An in-range read SHALL return the memory word as of the acceptance edge, including any write accepted on an earlier edge.
REQ-026 An out-of-range request SHALL not modify memory, and its response SHALL carry rsp_err=1 and rsp_rdata=0.
REQ-027 Addresses SHALL never wrap; an address >= DEPTH is always an error.
REQ-028 init_start=1 in RUN SHALL enter INIT on the next edge, and req_ready SHALL drop on that same edge.
REQ-029 A request offered in the same cycle as init_start SHALL still be accepted, because req_ready was 1 in that cycle.
REQ-030 Responses already in flight SHALL complete normally while a sweep runs.
REQ-031 init_start in INIT SHALL be ignored; the sweep is not restarted.
REQ-032 Memory contents SHALL not be cleared by clear_n itself; only a sweep zeroes them.

Reset
REQ-033 While clear_n=0: pipeline flushed, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0, sweep counter=0.
REQ-034 While clear_n=0, the FSM SHALL be held in INIT if INIT_ON_RESET=1, or in RUN if INIT_ON_RESET=0.
REQ-035 Asserting clear_n mid-sweep or mid-pipeline SHALL abort all activity; in-flight responses are dropped, never delivered.
REQ-036 After release, with INIT_ON_RESET=1, the sweep SHALL restart from address 0.
REQ-037 With INIT_ON_RESET=0, req_ready SHALL be 1 on the first cycle after release, and memory contents are undefined until written.

Verification
Bench parameters for all scenarios: DATA_W=16, ADDR_W=6, DEPTH=48, RD_LAT=2, INIT_ON_RESET=1.
REQ-038 Reset sweep: release clear_n, hold req_valid=1 -> req_ready=0 for exactly 48 cycles, then 1; a read of address 47 returns 0x0000.
REQ-039 Byte mask: write 0xABCD mask 11 to addr 5, then write 0x1234 mask 01 to addr 5, then read addr 5 -> rsp_rdata=0xAB34, 2 cycles after the read is accepted.
REQ-040 Back-to-back: write 0x0011 to addr 3, read addr 3 in the next cycle, read addr 3 in the cycle after -> three consecutive rsp_valid pulses; the two reads return 0x0011.
REQ-041 Out of range: write 0xFFFF to addr 50, then read addr 50 -> both responses have rsp_err=1 and rsp_rdata=0; a full memory dump shows no change.
REQ-042 Mid-operation events: init_start pulsed while a read of addr 5 (holding 0xAB34) is in flight -> that response returns 0xAB34, then req_ready=0 for 48 cycles, and a later read of addr 5 returns 0.
REQ-043 Reset abort: assert clear_n low one cycle after a read is accepted -> no rsp_valid ever appears for that read, and the sweep restarts at address 0 after release.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl
//   Single-port word memory with a byte-masked write path, a fixed-latency
//   in-order response pipeline, and a zero-fill sweep. The sweep runs after
//   reset (when INIT_ON_RESET=1) or on an init_start pulse.
//
// Handshake: a request transfers on a rising clk edge where req_valid=1 and
//   req_ready=1. Each transfer yields exactly one response exactly RD_LAT
//   cycles later. rsp_valid is a one-cycle pulse, and responses cannot be
//   back-pressured.
//
// Ports
//   clk         clock, rising edge
//   clear_n     asynchronous active-low reset
//   req_valid   request present
//   req_ready   request accepted this cycle (only in RUN)
//   req_write   1 = write, 0 = read
//   req_addr    word address (>= DEPTH is an error)
//   req_wdata   write data
//   req_wmask   byte enables for writes
//   init_start  pulse: start a zero-fill sweep (ignored while sweeping)
//   rsp_valid   response pulse
//   rsp_rdata   read data (0 for writes, errors and idle cycles)
//   rsp_err     out-of-range request, qualified by rsp_valid
//   fsm_state   debug view of the FSM: 0 = INIT, 1 = RUN
module data_mem_ctrl #(
  parameter int DATA_W        = 16,
  parameter int ADDR_W        = 6,
  parameter int DEPTH         = 64,
  parameter int RD_LAT        = 1,
  parameter int INIT_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                clear_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wmask,
  input  logic                init_start,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                fsm_state
);

  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;
  localparam state_t RST_STATE = (INIT_ON_RESET != 0) ? INIT : RUN;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              in_range;
  logic              sweep_we;
  logic [DATA_W-1:0] rd_word;

  logic              pv [RD_LAT];
  logic              pe [RD_LAT];
  logic [DATA_W-1:0] pd [RD_LAT];

  // Ready is forced low while reset is held. This matters when
  // INIT_ON_RESET=0, because the FSM then sits in RUN during reset.
  assign req_ready = (state == RUN) && clear_n;
  assign accept    = req_valid && req_ready;
  assign in_range  = {1'b0, req_addr} < DEPTH_C;
  // Gate the sweep with clear_n so that holding reset never zeroes address 0.
  assign sweep_we  = (state == INIT) && clear_n;
  assign fsm_state = (state == RUN);

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state <= RST_STATE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      INIT: begin
        // init_start is deliberately ignored here; the sweep never restarts.
        if (cnt == LAST) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RUN: begin
        if (init_start) begin
          state_nxt = INIT;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = RST_STATE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // ---------------- Memory ----------------
  // Sweep writes and request writes are mutually exclusive, because requests
  // are accepted only in RUN. The array has no reset, so contents survive
  // clear_n.
  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem[cnt] <= '0;
    end else if (accept && req_write && in_range) begin
      for (int i = 0; i < NB; i++) begin
        if (req_wmask[i]) mem[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

  // The read is sampled at the acceptance edge. It therefore sees every
  // write committed on an earlier edge.
  always_comb begin
    rd_word = '0;
    if (in_range && !req_write) rd_word = mem[req_addr];
  end

  // ---------------- Response pipeline ----------------
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pv[i] <= 1'b0;
        pe[i] <= 1'b0;
        pd[i] <= '0;
      end
    end else begin
      pv[0] <= accept;
      pe[0] <= accept && !in_range;
      pd[0] <= accept ? rd_word : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        pv[i] <= pv[i-1];
        pe[i] <= pe[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end

  assign rsp_valid = pv[RD_LAT-1];
  assign rsp_err   = pv[RD_LAT-1] && pe[RD_LAT-1];
  assign rsp_rdata = pv[RD_LAT-1] ? pd[RD_LAT-1] : '0;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl
//   Self-checking bench for data_mem_ctrl (DATA_W=16, ADDR_W=6, DEPTH=48,
//   RD_LAT=2, INIT_ON_RESET=1).
//
//   Each accepted request pushes one expected response {due cycle, err, data}
//   onto exp_q. The expected data comes from a behavioural memory model kept
//   by the bench. A negedge monitor pops an entry on every rsp_valid and
//   checks the data, the error flag and the arrival cycle.
module tb_data_mem_ctrl;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 48;
  localparam int RD_LAT = 2;
  localparam int W      = 32 + 1 + DATA_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic clear_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic                req_valid = 1'b0;
  logic                req_ready;
  logic                req_write = 1'b0;
  logic [ADDR_W-1:0]   req_addr  = '0;
  logic [DATA_W-1:0]   req_wdata = '0;
  logic [DATA_W/8-1:0] req_wmask = '0;
  logic                init_start = 1'b0;
  logic                rsp_valid;
  logic [DATA_W-1:0]   rsp_rdata;
  logic                rsp_err;
  logic                fsm_state;

  data_mem_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
    .RD_LAT(RD_LAT), .INIT_ON_RESET(1)
  ) dut (
    .clk(clk), .clear_n(clear_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .init_start(init_start),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .fsm_state(fsm_state)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0]      exp_q[$];
  logic [DATA_W-1:0] model_mem [DEPTH];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("rsp_cycle", 32'(cyc), e[W-1 -: 32]);
        check_eq("rsp_err",   32'(rsp_err), 32'(e[DATA_W]));
        check_eq("rsp_rdata", 32'(rsp_rdata), 32'(e[DATA_W-1:0]));
      end
    end else if (exp_q.size() > 0 && int'(exp_q[0][W-1 -: 32]) <= cyc) begin
      e = exp_q.pop_front();
      check_eq("rsp_missing", 32'd0, 32'd1);
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge. Holds the request until it is accepted, then returns
  // at the negedge after the acceptance edge.
  task automatic issue(input logic w, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input logic [DATA_W/8-1:0] m);
    int waited = 0;
    logic ok;
    logic [DATA_W-1:0] exp_d;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_wmask = m;
    while (!req_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      check_eq("ready_timeout", 32'd0, 32'd1);
    end else begin
      ok    = (int'(a) < DEPTH);
      exp_d = '0;
      if (ok && !w) exp_d = model_mem[a];
      if (ok && w) begin
        for (int b = 0; b < DATA_W/8; b++)
          if (m[b]) model_mem[a][8*b +: 8] = d[8*b +: 8];
      end
      exp_q.push_back({32'(cyc + RD_LAT), !ok, exp_d});
      @(negedge clk);
    end
    req_valid = 1'b0;
  endtask

  // Counts the cycles with req_ready low. Also pulses init_start once
  // mid-sweep, and that pulse must not restart the sweep.
  task automatic wait_sweep(input string tag);
    int n = 0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    while (!req_ready && n < 200) begin
      init_start = (n == 10);
      @(negedge clk);
      n++;
    end
    init_start = 1'b0;
    check_eq(tag, 32'(n), 32'(DEPTH));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"}, 32'(req_ready), 32'd0);
    check_eq({tag, "_valid"}, 32'(rsp_valid), 32'd0);
    check_eq({tag, "_rdata"}, 32'(rsp_rdata), 32'd0);
    check_eq({tag, "_err"},   32'(rsp_err),   32'd0);
    check_eq({tag, "_fsm"},   32'(fsm_state), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int k;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");

    // Reset sweep with a read of the last address held pending throughout.
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 6'd47;
    clear_n   = 1'b1;
    wait_sweep("reset_sweep_len");
    check_eq("fsm_run", 32'(fsm_state), 32'd1);
    issue(1'b0, 6'd47, '0, '0);

    // Byte mask.
    issue(1'b1, 6'd5, 16'hABCD, 2'b11);
    issue(1'b1, 6'd5, 16'h1234, 2'b01);
    issue(1'b0, 6'd5, '0, '0);
    check_eq("model_abc34", 32'(model_mem[5]), 32'h0000AB34);

    // Back-to-back write then two reads of the same address.
    issue(1'b1, 6'd3, 16'h0011, 2'b11);
    issue(1'b0, 6'd3, '0, '0);
    issue(1'b0, 6'd3, '0, '0);

    // Out of range, then a full dump to confirm no corruption.
    issue(1'b1, 6'd50, 16'hFFFF, 2'b11);
    issue(1'b0, 6'd50, '0, '0);
    issue(1'b1, 6'd48, 16'hFFFF, 2'b11);
    issue(1'b0, 6'd63, '0, '0);
    for (int a = 0; a < DEPTH; a++) issue(1'b0, 6'(a), '0, '0);

    // Random traffic with occasional idle gaps.
    for (int i = 0; i < 60; i++) begin
      issue(1'($urandom_range(0, 1)), 6'($urandom_range(0, 55)),
            16'($urandom), 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    // init_start while a read is in flight. A read offered in the same cycle
    // as init_start must still be accepted.
    issue(1'b1, 6'd5, 16'hAB34, 2'b11);
    issue(1'b0, 6'd5, '0, '0);
    init_start = 1'b1;
    issue(1'b0, 6'd5, '0, '0);
    init_start = 1'b0;
    wait_sweep("init_sweep_len");
    issue(1'b0, 6'd5, '0, '0);
    issue(1'b0, 6'd47, '0, '0);

    // Reset abort with a read in flight.
    issue(1'b1, 6'd9, 16'h5A5A, 2'b11);
    repeat (3) @(negedge clk);
    issue(1'b0, 6'd9, '0, '0);
    clear_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_eq("abort_no_rsp", 32'(rsp_valid), 32'd0);
    repeat (2) @(negedge clk);
    check_reset_outputs("abort");
    clear_n = 1'b1;
    repeat (20) @(negedge clk);
    clear_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("abort_sweep");
    clear_n = 1'b1;
    wait_sweep("restart_sweep_len");
    issue(1'b0, 6'd9, '0, '0);
    issue(1'b0, 6'd0, '0, '0);

    // Drain.
    k = 0;
    while (exp_q.size() > 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check_eq("drain", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
